expr_sequencer: RTL and testbench
=================================

EXPR_SEQUENCER -- requirements
Module: expr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width.
REQ-002 SHALL have parameter OP_DEPTH, default 16, operator-stack entries.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port tok_valid, input, 1: token present.
REQ-007 SHALL have port tok_ready, output, 1: token accepted on a rising edge with tok_valid=1.
REQ-008 SHALL have port tok_type, input, 3: 000 '+', 001 '*', 010 '(', 011 ')', 100 operand, 111 end; 101/110 are syntax errors.
REQ-009 SHALL have port tok_data, input, DATA_WIDTH: operand value when tok_type=100.
REQ-010 SHALL have port alu_opcode, output, 3: 000 nop, 100 add, 101 mult, 110 push.
REQ-011 SHALL have port alu_data, output, DATA_WIDTH: push value.
REQ-012 SHALL have port alu_result, input, DATA_WIDTH: ALU top of stack.
REQ-013 SHALL have port alu_overflow, input, 1: ALU overflow flag.
REQ-014 SHALL have port result, output, DATA_WIDTH; result_valid, output, 1; error, output, 1.
REQ-015 SHALL have port busy, output, 1: high in any state except ACCEPT with an empty operator stack.

Function
REQ-016 SHALL implement infix evaluation with '*' binding tighter than '+', both left-associative, using an internal operator stack of '+', '*' and '(' entries.
REQ-017 SHALL use states ACCEPT, REDUCE, WAIT, DONE and ERR.
REQ-018 tok_ready SHALL equal 1 in ACCEPT and ERR only, and SHALL be decoded from the state register only.
REQ-019 In ACCEPT, an accepted operand SHALL issue push with alu_data=tok_data, and the block SHALL stay in ACCEPT.
REQ-020 In ACCEPT, an accepted '(' SHALL push '(' onto the operator stack, and the block SHALL stay in ACCEPT.
REQ-021 In ACCEPT, an accepted '+', '*', ')' or end SHALL be latched into a pending register, and the block SHALL go to REDUCE.
REQ-022 In REDUCE, the block SHALL pop at most one operator per cycle and issue the matching ALU op (add or mult) while the pop condition holds.
- Pending '*': pop while the top is '*'.
- Pending '+': pop while the top is '+' or '*'.
- Pending ')' or end: pop while the top is '+' or '*'.
REQ-023 When the REDUCE pop condition fails, the block SHALL take one finishing cycle and act as follows.
- Pending '+' or '*': push it, go to ACCEPT.
- Pending ')': top is '(' -> pop it, go to ACCEPT; stack empty -> ERR.
- Pending end: stack empty -> WAIT; top is '(' -> ERR.
REQ-024 alu_opcode and alu_data SHALL be registered, carry each command for exactly the one cycle after the issuing edge, and read 000 otherwise.
REQ-025 WAIT SHALL last 2 cycles, then go to DONE.
REQ-026 DONE SHALL last 1 cycle, register result=alu_result, pulse result_valid=1 with error=0, then return to ACCEPT.
REQ-027 The block SHALL track an expect_operand flag, set at reset, after an operator and after '('; cleared after an operand and after ')'.
- Operand or '(' accepted with the flag clear -> ERR.
- '+', '*', ')' or end accepted with the flag set -> ERR.
REQ-028 A push onto a full operator stack (OP_DEPTH entries) SHALL go to ERR, and the stack SHALL not be written.
REQ-029 alu_overflow=1 in any cycle other than ERR SHALL go to ERR.
REQ-030 ERR SHALL issue no ALU commands and SHALL discard tokens until an end token is accepted.
- On that edge: result_valid=1 and error=1 for one cycle; result keeps its last value.
- Then the operator stack and flags SHALL be cleared, and the block SHALL return to ACCEPT.
REQ-031 A type 101/110 token SHALL go to ERR.

Reset
REQ-032 While rst_n=0, the block SHALL hold state=ACCEPT, an empty operator stack, expect_operand=1, alu_opcode=000, alu_data=0, result=0, result_valid=0 and error=0.
REQ-033 Reset asserted mid-expression SHALL abandon the expression immediately, issuing no further ALU commands.

Verification
REQ-034 The bench SHALL cover tokens 2,+,3,end -> ALU ops push2, push3, add, with result=5 and error=0.
REQ-035 The bench SHALL cover tokens 2,+,3,*,4,end -> push2, push3, push4, mult, add, with result=14.
REQ-036 The bench SHALL cover tokens (,2,+,3,),*,4,end -> push2, push3, add, push4, mult, with result=20.
REQ-037 The bench SHALL cover tokens 2,*,3,+,4,end -> push2, push3, mult, push4, add, with result=10, and tok_ready low during each REDUCE cycle.
REQ-038 The bench SHALL cover tokens 2,),5,end -> ERR after ')', with a single result_valid=1 and error=1 on end, and no push5 issued.
REQ-039 The bench SHALL cover OP_DEPTH+1 consecutive '(' -> error on end with no stack corruption, then 1,end -> result=1 with error=0.
REQ-040 The bench SHALL cover rst_n pulsed low mid-expression -> all outputs at reset values, then a fresh 7,end -> result=7.

Source files
------------

// File: rtl/expr_sequencer.sv
// rtl/expr_sequencer.sv - infix '+'/'*' expression sequencer driving a stack ALU
module expr_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int OP_DEPTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic [2:0]            tok_type,
    input  logic [DATA_WIDTH-1:0] tok_data,
    output logic [2:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_overflow,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    output logic                  error,
    output logic                  busy
);

    localparam int CW = $clog2(OP_DEPTH + 1);
    localparam int IW = $clog2(OP_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(OP_DEPTH);

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_MUL = 3'b001;
    localparam logic [2:0] T_LP  = 3'b010;
    localparam logic [2:0] T_RP  = 3'b011;
    localparam logic [2:0] T_NUM = 3'b100;
    localparam logic [2:0] T_END = 3'b111;

    localparam logic [2:0] A_NOP  = 3'b000;
    localparam logic [2:0] A_ADD  = 3'b100;
    localparam logic [2:0] A_MUL  = 3'b101;
    localparam logic [2:0] A_PUSH = 3'b110;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_LP  = 2'd2;

    typedef enum logic [2:0] {S_ACCEPT, S_REDUCE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t                        state_q, state_d;
    logic [OP_DEPTH-1:0][1:0]      stk_q, stk_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          expect_q, expect_d;
    logic [2:0]                    pend_q, pend_d;
    logic                          wait_q, wait_d;
    logic [2:0]                    op_q, op_d;
    logic [DATA_WIDTH-1:0]         data_q, data_d;
    logic [DATA_WIDTH-1:0]         result_q, result_d;
    logic                          rv_q, rv_d;
    logic                          err_q, err_d;

    logic       empty, full, pop;
    logic [1:0] top;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL);
    assign top   = stk_q[IW'(cnt_q - 1'b1)];
    // '*' only unwinds other '*'; everything else unwinds down to '(' or empty
    assign pop   = !empty && ((pend_q == T_MUL) ? (top == OP_MUL) : (top != OP_LP));

    always_comb begin
        state_d  = state_q;
        stk_d    = stk_q;
        cnt_d    = cnt_q;
        expect_d = expect_q;
        pend_d   = pend_q;
        wait_d   = wait_q;
        op_d     = A_NOP;
        data_d   = '0;
        result_d = result_q;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_ACCEPT: if (tok_valid) begin
                case (tok_type)
                    T_NUM: begin
                        if (!expect_q) state_d = S_ERR;
                        else begin
                            op_d     = A_PUSH;
                            data_d   = tok_data;
                            expect_d = 1'b0;
                        end
                    end
                    T_LP: begin
                        if (!expect_q || full) state_d = S_ERR;
                        else begin
                            stk_d[IW'(cnt_q)] = OP_LP;
                            cnt_d             = cnt_q + 1'b1;
                            expect_d          = 1'b1;
                        end
                    end
                    T_ADD, T_MUL, T_RP, T_END: begin
                        if (expect_q) state_d = S_ERR;
                        else begin
                            pend_d   = tok_type;
                            state_d  = S_REDUCE;
                            expect_d = (tok_type == T_ADD) || (tok_type == T_MUL);
                        end
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_REDUCE: begin
                if (pop) begin
                    cnt_d = cnt_q - 1'b1;
                    op_d  = (top == OP_MUL) ? A_MUL : A_ADD;
                end else begin
                    case (pend_q)
                        T_ADD, T_MUL: begin
                            if (full) state_d = S_ERR;
                            else begin
                                stk_d[IW'(cnt_q)] = (pend_q == T_MUL) ? OP_MUL : OP_ADD;
                                cnt_d             = cnt_q + 1'b1;
                                state_d           = S_ACCEPT;
                            end
                        end
                        T_RP: begin
                            if (!empty && top == OP_LP) begin
                                cnt_d   = cnt_q - 1'b1;
                                state_d = S_ACCEPT;
                            end else state_d = S_ERR;
                        end
                        default: begin
                            if (empty) begin
                                state_d = S_WAIT;
                                wait_d  = 1'b0;
                            end else state_d = S_ERR;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                wait_d = 1'b1;
                if (wait_q) state_d = S_DONE;
            end
            S_DONE: begin
                result_d = alu_result;
                rv_d     = 1'b1;
                cnt_d    = '0;
                expect_d = 1'b1;
                state_d  = S_ACCEPT;
            end
            default: begin
                if (tok_valid && tok_type == T_END) begin
                    rv_d     = 1'b1;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    expect_d = 1'b1;
                    state_d  = S_ACCEPT;
                end
            end
        endcase
        // ALU overflow wins over whatever this cycle would have done
        if (alu_overflow && state_q != S_ERR) begin
            state_d  = S_ERR;
            stk_d    = stk_q;
            cnt_d    = cnt_q;
            op_d     = A_NOP;
            data_d   = '0;
            result_d = result_q;
            rv_d     = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ACCEPT;
            stk_q    <= '0;
            cnt_q    <= '0;
            expect_q <= 1'b1;
            pend_q   <= T_END;
            wait_q   <= 1'b0;
            op_q     <= A_NOP;
            data_q   <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stk_q    <= stk_d;
            cnt_q    <= cnt_d;
            expect_q <= expect_d;
            pend_q   <= pend_d;
            wait_q   <= wait_d;
            op_q     <= op_d;
            data_q   <= data_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign tok_ready    = (state_q == S_ACCEPT) || (state_q == S_ERR);
    assign busy         = !((state_q == S_ACCEPT) && empty);
    assign alu_opcode   = op_q;
    assign alu_data     = data_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign error        = err_q;

endmodule

// File: tb/tb_expr_sequencer.sv
// tb/tb_expr_sequencer.sv - scoreboard bench for expr_sequencer with a stack ALU model
module tb_expr_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_MUL = 3'b001;
    localparam logic [2:0] T_LP  = 3'b010;
    localparam logic [2:0] T_RP  = 3'b011;
    localparam logic [2:0] T_NUM = 3'b100;
    localparam logic [2:0] T_END = 3'b111;

    localparam logic [2:0] A_ADD  = 3'b100;
    localparam logic [2:0] A_MUL  = 3'b101;
    localparam logic [2:0] A_PUSH = 3'b110;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tok_valid;
    logic          tok_ready;
    logic [2:0]    tok_type;
    logic [DW-1:0] tok_data;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] alu_result = '0;
    logic          alu_overflow;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          error;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int s;

    logic [18:0]   op_q[$];
    logic [16:0]   res_q[$];
    logic [DW-1:0] alu_stk[$];

    always #5 clk = ~clk;

    expr_sequencer #(.DATA_WIDTH(DW), .OP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_type(tok_type), .tok_data(tok_data), .alu_opcode(alu_opcode),
        .alu_data(alu_data), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .result(result), .result_valid(result_valid), .error(error), .busy(busy)
    );

    function automatic logic [DW-1:0] pop_val();
        if (alu_stk.size() == 0) return '0;
        return alu_stk.pop_back();
    endfunction

    always @(posedge clk) begin
        case (alu_opcode)
            A_PUSH:  alu_stk.push_back(alu_data);
            A_ADD:   alu_stk.push_back(pop_val() + pop_val());
            A_MUL:   alu_stk.push_back(pop_val() * pop_val());
            default: ;
        endcase
        alu_result <= (alu_stk.size() > 0) ? alu_stk[$] : '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [18:0] e;
        logic [16:0] r;
        @(negedge clk);
        if (alu_opcode !== 3'b000) begin
            if (op_q.size() == 0) chk("stray_alu_op", 32'(alu_opcode), 32'd0);
            else begin
                e = op_q.pop_front();
                chk("alu_opcode", 32'(alu_opcode), 32'(e[18:16]));
                if (e[18:16] == A_PUSH) chk("alu_data", 32'(alu_data), 32'(e[15:0]));
            end
        end
        if (result_valid !== 1'b0) begin
            if (res_q.size() == 0) chk("stray_result_valid", 32'(result_valid), 32'd0);
            else begin
                r = res_q.pop_front();
                chk("result", 32'(result), 32'(r[15:0]));
                chk("error", 32'(error), 32'(r[16]));
            end
        end
    endtask

    task automatic send(input logic [2:0] t, input logic [DW-1:0] d, output int stalls);
        tok_valid = 1'b1;
        tok_type  = t;
        tok_data  = d;
        stalls    = 0;
        while (!tok_ready && stalls < 100) begin
            tick();
            stalls++;
        end
        if (stalls >= 100) chk("tok_ready_timeout", 32'(tok_ready), 32'd1);
        tick();
        tok_valid = 1'b0;
    endtask

    task automatic exp_push(input logic [DW-1:0] v);
        op_q.push_back({A_PUSH, v});
    endtask

    task automatic exp_op(input logic [2:0] code);
        op_q.push_back({code, 16'h0});
    endtask

    task automatic exp_res(input logic [DW-1:0] v, input logic e);
        res_q.push_back({e, v});
    endtask

    task automatic drain();
        int n = 0;
        while ((op_q.size() != 0 || res_q.size() != 0) && n < 80) begin
            tick();
            n++;
        end
        chk("drain_pending", 32'(op_q.size() + res_q.size()), 32'd0);
        op_q.delete();
        res_q.delete();
        repeat (4) tick();
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
        chk({tag, "_alu_data"}, 32'(alu_data), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_tok_ready"}, 32'(tok_ready), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        tok_valid    = 1'b0;
        tok_type     = T_END;
        tok_data     = '0;
        alu_overflow = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // 2 + 3
        exp_push(2); exp_push(3); exp_op(A_ADD); exp_res(5, 1'b0);
        send(T_NUM, 2, s); send(T_ADD, 0, s); send(T_NUM, 3, s); send(T_END, 0, s);
        drain();

        // 2 + 3 * 4
        exp_push(2); exp_push(3); exp_push(4); exp_op(A_MUL); exp_op(A_ADD); exp_res(14, 1'b0);
        send(T_NUM, 2, s); send(T_ADD, 0, s); send(T_NUM, 3, s); send(T_MUL, 0, s);
        send(T_NUM, 4, s);
        chk("stall_after_mul_over_add", 32'(s), 32'd1);
        send(T_END, 0, s);
        drain();

        // (2 + 3) * 4
        exp_push(2); exp_push(3); exp_op(A_ADD); exp_push(4); exp_op(A_MUL); exp_res(20, 1'b0);
        send(T_LP, 0, s); send(T_NUM, 2, s); send(T_ADD, 0, s); send(T_NUM, 3, s);
        send(T_RP, 0, s); send(T_MUL, 0, s); send(T_NUM, 4, s); send(T_END, 0, s);
        drain();

        // 2 * 3 + 4: '+' spends one pop cycle and one push cycle in REDUCE
        exp_push(2); exp_push(3); exp_op(A_MUL); exp_push(4); exp_op(A_ADD); exp_res(10, 1'b0);
        send(T_NUM, 2, s); send(T_MUL, 0, s); send(T_NUM, 3, s); send(T_ADD, 0, s);
        send(T_NUM, 4, s);
        chk("stall_reduce_plus", 32'(s), 32'd2);
        send(T_END, 0, s);
        drain();

        // 2 ) 5 end: unmatched ')', 5 must be swallowed, result holds 10
        exp_push(2); exp_res(10, 1'b1);
        send(T_NUM, 2, s); send(T_RP, 0, s); send(T_NUM, 5, s); send(T_END, 0, s);
        drain();

        // operator stack overflow, then a clean expression
        for (int i = 0; i < DEPTH; i++) send(T_LP, 0, s);
        chk("busy_with_open_parens", 32'(busy), 32'd1);
        exp_res(10, 1'b1);
        send(T_LP, 0, s); send(T_END, 0, s);
        drain();
        exp_push(1); exp_res(1, 1'b0);
        send(T_NUM, 1, s); send(T_END, 0, s);
        drain();

        // reset in the middle of 2 + ...
        exp_push(2);
        send(T_NUM, 2, s); send(T_ADD, 0, s);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) tick();
        chk("mid_reset_hold_opcode", 32'(alu_opcode), 32'd0);
        rst_n = 1'b1;
        tick();
        exp_push(7); exp_res(7, 1'b0);
        send(T_NUM, 7, s); send(T_END, 0, s);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
